// File: rtl/krnl_multi_ch_ctrl.sv
// -----------------------------------------------------------------------------
// krnl_multi_ch_ctrl
//
// Purpose:
//   Host-facing ap_ctrl controller that fans a single host start out to up to
//   C_NUM_CHANNELS engine channels. It then waits until every enabled channel
//   has reported done, and returns a single ap_done to the host. The channel
//   mask and the transfer size are latched when the host start is accepted.
//   Later changes on the control inputs do not affect a run in progress.
//   busy_cycles counts the cycles spent in START and RUN. It saturates at
//   all-ones and holds its value until the next run is accepted.
//
// Configuration:
//   KRNL_MULTI_CH_CTRL_CHAIN_EN
//     Undefined (default): DONE lasts one cycle and ap_continue is ignored.
//     Defined: DONE (ap_done=1) is held until ap_continue=1. ap_ready pulses
//              only on the cycle DONE is entered.
//
// Ports:
//   ap_clk                  in   kernel clock, rising edge
//   areset                  in   synchronous active-high reset
//   ap_start                in   host start request (level)
//   ap_continue             in   host acknowledge of done (chain mode only)
//   ap_idle                 out  controller idle
//   ap_done                 out  all enabled channels finished
//   ap_ready                out  ready for next start (DONE entry cycle)
//   ctrl_channel_mask       in   [C_NUM_CHANNELS] channels enabled for a run
//   ctrl_xfer_size_in_bytes in   [C_XFER_SIZE_WIDTH] per-channel size
//   ch_start                out  [C_NUM_CHANNELS] one-cycle start pulses
//   ch_xfer_size            out  [C_XFER_SIZE_WIDTH] latched transfer size
//   ch_done                 in   [C_NUM_CHANNELS] one-cycle done pulses
//   busy_cycles             out  [C_CYCLE_CNT_WIDTH] cycles of last/current run
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module krnl_multi_ch_ctrl #(
    parameter int C_NUM_CHANNELS    = 4,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int C_CYCLE_CNT_WIDTH = 32
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    input  logic                         ap_continue,
    output logic                         ap_idle,
    output logic                         ap_done,
    output logic                         ap_ready,
    input  logic [C_NUM_CHANNELS-1:0]    ctrl_channel_mask,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
    output logic [C_NUM_CHANNELS-1:0]    ch_start,
    output logic [C_XFER_SIZE_WIDTH-1:0] ch_xfer_size,
    input  logic [C_NUM_CHANNELS-1:0]    ch_done,
    output logic [C_CYCLE_CNT_WIDTH-1:0] busy_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                         r_state;
    logic [C_NUM_CHANNELS-1:0]      r_mask;
    logic [C_NUM_CHANNELS-1:0]      r_sticky;
    logic [C_NUM_CHANNELS-1:0]      r_ch_start;
    logic [C_XFER_SIZE_WIDTH-1:0]   r_xfer_size;
    logic [C_CYCLE_CNT_WIDTH-1:0]   r_busy_cycles;
    logic                           r_ap_idle;
    logic                           r_ap_done;
    logic                           r_ap_ready;

    logic [C_NUM_CHANNELS-1:0]      w_sticky_next;
    logic                           w_all_done;
    logic                           w_busy_sat;
    logic [C_CYCLE_CNT_WIDTH-1:0]   w_busy_next;

`ifndef KRNL_MULTI_CH_CTRL_CHAIN_EN
    // ap_continue has no function when DONE self-terminates.
    logic                           w_unused_continue;
    assign w_unused_continue = ap_continue;
`endif

    // Per-channel done-sticky update. Done pulses from channels outside the
    // latched mask never set a bit. A channel that is already done stays
    // done, so repeated pulses are harmless.
    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_sticky
            assign w_sticky_next[gi] = r_sticky[gi] | (ch_done[gi] & r_mask[gi]);
        end
    endgenerate

    // Completion includes done pulses arriving in the current cycle. This
    // makes DONE follow the last required done by exactly one cycle.
    assign w_all_done  = (w_sticky_next == r_mask);

    assign w_busy_sat  = &r_busy_cycles;
    assign w_busy_next = w_busy_sat ? r_busy_cycles
                                    : r_busy_cycles + C_CYCLE_CNT_WIDTH'(1);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            r_state       <= ST_IDLE;
            r_mask        <= '0;
            r_sticky      <= '0;
            r_ch_start    <= '0;
            r_xfer_size   <= '0;
            r_busy_cycles <= '0;
            r_ap_idle     <= 1'b1;
            r_ap_done     <= 1'b0;
            r_ap_ready    <= 1'b0;
        end else begin
            // Pulse-type outputs default low. They are raised only on the
            // transition edges below.
            r_ch_start <= '0;
            r_ap_ready <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_mask        <= ctrl_channel_mask;
                        r_xfer_size   <= ctrl_xfer_size_in_bytes;
                        r_sticky      <= '0;
                        r_busy_cycles <= '0;
                        r_ap_idle     <= 1'b0;
                        if (ctrl_channel_mask == '0) begin
                            // Nothing to launch, so complete immediately.
                            r_state    <= ST_DONE;
                            r_ap_done  <= 1'b1;
                            r_ap_ready <= 1'b1;
                        end else begin
                            r_state    <= ST_START;
                            r_ch_start <= ctrl_channel_mask;
                        end
                    end
                end

                ST_START: begin
                    // Completion is not evaluated here. START always lasts
                    // exactly one cycle. Dones seen now are kept in the
                    // sticky register for RUN.
                    r_sticky      <= w_sticky_next;
                    r_busy_cycles <= w_busy_next;
                    r_state       <= ST_RUN;
                end

                ST_RUN: begin
                    r_sticky      <= w_sticky_next;
                    r_busy_cycles <= w_busy_next;
                    if (w_all_done) begin
                        r_state    <= ST_DONE;
                        r_ap_done  <= 1'b1;
                        r_ap_ready <= 1'b1;
                    end
                end

                ST_DONE: begin
`ifdef KRNL_MULTI_CH_CTRL_CHAIN_EN
                    if (ap_continue) begin
                        r_state   <= ST_IDLE;
                        r_ap_done <= 1'b0;
                        r_ap_idle <= 1'b1;
                    end
`else
                    r_state   <= ST_IDLE;
                    r_ap_done <= 1'b0;
                    r_ap_idle <= 1'b1;
`endif
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_ap_done <= 1'b0;
                    r_ap_idle <= 1'b1;
                end
            endcase
        end
    end

    assign ap_idle      = r_ap_idle;
    assign ap_done      = r_ap_done;
    assign ap_ready     = r_ap_ready;
    assign ch_start     = r_ch_start;
    assign ch_xfer_size = r_xfer_size;
    assign busy_cycles  = r_busy_cycles;

endmodule

// File: tb/tb_krnl_multi_ch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_krnl_multi_ch_ctrl
//
// Self-checking bench for krnl_multi_ch_ctrl.
//
// Each run is described by a channel mask, a transfer size and a done offset
// for every channel. The offset counts cycles after the ch_start cycle. The
// reference model works at the level of a whole run:
//   - ch_start equals the mask on the cycle after the start is accepted.
//   - ap_done appears at offset max(last masked done offset, 1) + 1.
//   - busy_cycles at DONE equals that offset.
//   - For a mask of zero, DONE is entered immediately, with busy_cycles = 0.
//
// Extra stimulus is applied during each run:
//   - random ap_start;
//   - changing mask/size inputs;
//   - pulses on unmasked channels;
//   - repeated pulses on channels that are already done.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_krnl_multi_ch_ctrl;

    localparam int N  = 4;
    localparam int XW = 32;
    localparam int CW = 32;

    logic          ap_clk = 1'b0;
    logic          areset = 1'b1;
    logic          ap_start = 1'b0;
    logic          ap_continue = 1'b0;
    logic          ap_idle;
    logic          ap_done;
    logic          ap_ready;
    logic [N-1:0]  ctrl_channel_mask = '0;
    logic [XW-1:0] ctrl_xfer_size_in_bytes = '0;
    logic [N-1:0]  ch_start;
    logic [XW-1:0] ch_xfer_size;
    logic [N-1:0]  ch_done = '0;
    logic [CW-1:0] busy_cycles;

    krnl_multi_ch_ctrl #(
        .C_NUM_CHANNELS    (N),
        .C_XFER_SIZE_WIDTH (XW),
        .C_CYCLE_CNT_WIDTH (CW)
    ) dut (
        .ap_clk                  (ap_clk),
        .areset                  (areset),
        .ap_start                (ap_start),
        .ap_continue             (ap_continue),
        .ap_idle                 (ap_idle),
        .ap_done                 (ap_done),
        .ap_ready                (ap_ready),
        .ctrl_channel_mask       (ctrl_channel_mask),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ch_start                (ch_start),
        .ch_xfer_size            (ch_xfer_size),
        .ch_done                 (ch_done),
        .busy_cycles             (busy_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_err = 0;
    int off [N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge. Outputs are sampled 1 ns after the edge, and
    // the inputs for the next edge are driven at the same point.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Precondition: the DUT is observed in IDLE.
    // Postcondition: the DUT is observed back in IDLE.
    task automatic run_one(input logic [N-1:0] mask, input logic [XW-1:0] size,
                           input bit b2b, input logic [N-1:0] nmask,
                           input logic [XW-1:0] nsize);
        int           m;
        int           exp_off;
        int           k;
        bit           seen;
        logic [N-1:0] d;
        logic [N-1:0] dsf;
        logic [N-1:0] exp_cs;

        m = 0;
        for (int i = 0; i < N; i++)
            if (mask[i] && off[i] > m) m = off[i];
        exp_off = (mask == '0) ? 0 : (((m < 1) ? 1 : m) + 1);

        ap_start                = 1'b1;
        ctrl_channel_mask       = mask;
        ctrl_xfer_size_in_bytes = size;
        ch_done                 = N'($urandom);   // ignored in IDLE
        ap_continue             = 1'b0;
        tick();

        seen = 1'b0;
        for (int o = 0; o <= 60 && !seen; o++) begin
            exp_cs = (o == 0) ? mask : '0;
            chk("ch_start", ch_start, exp_cs);
            if (o == exp_off) begin
                seen = 1'b1;
                chk("ap_done", ap_done, 1);
                chk("ap_ready", ap_ready, 1);
                chk("ap_idle_in_done", ap_idle, 0);
                chk("busy_cycles", busy_cycles, exp_off);
                chk("ch_xfer_size", ch_xfer_size, size);
                ch_done                 = '0;
                ap_start                = b2b;
                ctrl_channel_mask       = b2b ? nmask : N'($urandom);
                ctrl_xfer_size_in_bytes = b2b ? nsize : XW'($urandom);
`ifdef KRNL_MULTI_CH_CTRL_CHAIN_EN
                k = $urandom_range(0, 10);
                for (int j = 0; j < k; j++) begin
                    ap_continue = 1'b0;
                    tick();
                    chk("ap_done_held", ap_done, 1);
                    chk("ap_ready_once", ap_ready, 0);
                    chk("ap_idle_held", ap_idle, 0);
                end
                ap_continue = 1'b1;
`else
                k = 0;
                ap_continue = 1'($urandom_range(0, 1));
`endif
                tick();
                ap_continue = 1'b0;
                chk("ap_idle_after", ap_idle, 1);
                chk("ap_done_after", ap_done, 0);
                chk("ap_ready_after", ap_ready, 0);
                chk("busy_hold", busy_cycles, exp_off);
                chk("xfer_hold", ch_xfer_size, size);
            end else begin
                chk("ap_done_early", ap_done, 0);
                chk("ap_idle_run", ap_idle, 0);
                d   = '0;
                dsf = '0;
                for (int i = 0; i < N; i++) begin
                    if (off[i] == o) d[i] = 1'b1;
                    if (mask[i] && off[i] < o) dsf[i] = 1'b1;
                end
                // Noise is limited to unmasked channels and to masked
                // channels that are already done.
                ch_done                 = d | (N'($urandom) & (~mask | dsf));
                ap_start                = 1'($urandom_range(0, 1));
                ctrl_channel_mask       = N'($urandom);
                ctrl_xfer_size_in_bytes = XW'($urandom);
                tick();
            end
        end
        if (!seen) chk("done_seen", seen, 1);
        $display("run mask=%b size=%0d done_off=%0d busy=%0d b2b=%0d hold=%0d",
                 mask, size, exp_off, busy_cycles, b2b, k);
    endtask

    task automatic reset_mid_run();
        ap_start                = 1'b1;
        ctrl_channel_mask       = 4'b1111;
        ctrl_xfer_size_in_bytes = 32'd4096;
        ch_done                 = '0;
        tick();                                  // START
        ap_start = 1'b0;
        ch_done  = 4'b0001;
        tick();                                  // RUN, offset 1
        ch_done  = 4'b0010;
        tick();                                  // offset 2
        ch_done  = '0;
        tick();                                  // offset 3
        chk("rst_pre_done", ap_done, 0);
        areset = 1'b1;
        tick();
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_ch_start", ch_start, 0);
        chk("rst_busy", busy_cycles, 0);
        chk("rst_xfer", ch_xfer_size, 0);
        areset  = 1'b0;
        ch_done = 4'b1100;                       // late dones, ignored in IDLE
        tick();
        ch_done = 4'b1111;
        tick();
        ch_done = '0;
        chk("post_rst_idle", ap_idle, 1);
        chk("post_rst_done", ap_done, 0);
        $display("reset mid-run after 2 of 4 dones: idle=%0d done=%0d", ap_idle, ap_done);
    endtask

    logic [N-1:0]  cur_mask;
    logic [N-1:0]  nxt_mask;
    logic [XW-1:0] cur_size;
    logic [XW-1:0] nxt_size;
    bit            b2b;

    initial begin
        areset = 1'b1;
        repeat (3) tick();
        chk("reset_idle", ap_idle, 1);
        chk("reset_done", ap_done, 0);
        chk("reset_ready", ap_ready, 0);
        chk("reset_ch_start", ch_start, 0);
        chk("reset_xfer", ch_xfer_size, 0);
        chk("reset_busy", busy_cycles, 0);
        areset = 1'b0;
        tick();

        // All four channels; the last done at offset 20 gives busy = 21.
        off[0] = 5; off[1] = 9; off[2] = 9; off[3] = 20;
        run_one(4'b1111, 32'd16384, 1'b0, 4'b0, 32'd0);

        // Unmasked channels finish first; the masked ones finish later.
        off[0] = 15; off[1] = 2; off[2] = 18; off[3] = 4;
        run_one(4'b0101, 32'd512, 1'b0, 4'b0, 32'd0);

        // Empty mask.
        run_one(4'b0000, 32'd77, 1'b0, 4'b0, 32'd0);

        // Reset in RUN; then a fresh run must wait for all four channels.
        reset_mid_run();
        off[0] = 3; off[1] = 3; off[2] = 8; off[3] = 12;
        run_one(4'b1111, 32'd8192, 1'b0, 4'b0, 32'd0);

        // ap_start held across DONE into a second run with new settings.
        off[0] = 2; off[1] = 6; off[2] = 1; off[3] = 4;
        run_one(4'b1011, 32'd1000, 1'b1, 4'b0110, 32'd2000);
        off[0] = 9; off[1] = 3; off[2] = 7; off[3] = 0;
        run_one(4'b0110, 32'd2000, 1'b0, 4'b0, 32'd0);

        // Randomized runs.
        cur_mask = N'($urandom);
        cur_size = XW'($urandom);
        for (int r = 0; r < 30; r++) begin
            nxt_mask = N'($urandom);
            nxt_size = XW'($urandom);
            b2b      = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) off[i] = $urandom_range(0, 25);
            run_one(cur_mask, cur_size, b2b, nxt_mask, nxt_size);
            cur_mask = nxt_mask;
            cur_size = nxt_size;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/krnl_multi_ch_ctrl.md
KRNL_MULTI_CH_CTRL -- requirements
Module: krnl_multi_ch_ctrl

Interface
REQ-001 SHALL have parameter C_NUM_CHANNELS, default 4, number of managed engine channels (1..16).
REQ-002 SHALL have parameter C_XFER_SIZE_WIDTH, default 32, width of transfer-size field.
REQ-003 SHALL have parameter C_CYCLE_CNT_WIDTH, default 32, width of busy-cycle counter.
REQ-004 ap_clk  input  1  kernel clock; all logic on rising edge.
REQ-005 areset  input  1  reset, synchronous, active-high.
REQ-006 ap_start  input  1  host start request (level).
REQ-007 ap_continue  input  1  host acknowledge of done (chain mode only).
REQ-008 ap_idle  output  1  block idle.
REQ-009 ap_done  output  1  all enabled channels finished.
REQ-010 ap_ready  output  1  ready for next start.
REQ-011 ctrl_channel_mask  input  C_NUM_CHANNELS  channels enabled for this run.
REQ-012 ctrl_xfer_size_in_bytes  input  C_XFER_SIZE_WIDTH  per-channel transfer size.
REQ-013 ch_start  output  C_NUM_CHANNELS  one-cycle start pulse per channel.
REQ-014 ch_xfer_size  output  C_XFER_SIZE_WIDTH  latched transfer size for all channels.
REQ-015 ch_done  input  C_NUM_CHANNELS  one-cycle done pulse per channel.
REQ-016 busy_cycles  output  C_CYCLE_CNT_WIDTH  cycles spent in last/current run.

Function
REQ-017 SHALL implement registered FSM with states IDLE, START, RUN, DONE.
REQ-018 IDLE: ap_idle=1; if ap_start=1, latch ctrl_channel_mask and ctrl_xfer_size_in_bytes, go to START next cycle.
REQ-019 IDLE with ap_start=1 and ctrl_channel_mask=0: go directly to DONE, no ch_start asserted.
REQ-020 START (exactly one cycle): ch_start = latched mask, clear done-sticky register, clear busy_cycles, go to RUN.
REQ-021 ch_start SHALL be zero in every state other than START.
REQ-022 Done-sticky SHALL OR in (ch_done & latched mask) in START and RUN; ch_done on unmasked channels ignored.
REQ-023 RUN: when (sticky | masked ch_done of current cycle) equals latched mask, go to DONE next cycle.
REQ-024 Repeated ch_done on an already-done channel SHALL have no effect.
REQ-025 DONE: ap_done=1, ap_ready=1 on DONE entry cycle; ap_idle=0.
REQ-026 ap_start while not in IDLE SHALL be ignored; mask/size inputs changing mid-run SHALL NOT affect ch_xfer_size or completion.
REQ-027 busy_cycles SHALL increment once per cycle in START and RUN, saturate at all-ones, hold value from DONE until next START.
REQ-028 Latency: ap_start sampled in IDLE at cycle t -> ch_start at t+1; last required ch_done at cycle r -> ap_done at r+1.

Reset
REQ-029 areset=1 SHALL force state IDLE within one cycle, regardless of current state.
REQ-030 Reset values: ap_idle=1, ap_done=0, ap_ready=0, ch_start=0, ch_xfer_size=0, busy_cycles=0, sticky=0, latched mask=0.
REQ-031 Reset mid-run SHALL discard pending completion; ch_done arriving after reset deassertion in IDLE ignored.

Configuration
REQ-032 Macro KRNL_MULTI_CH_CTRL_CHAIN_EN defined: DONE held (ap_done=1) until ap_continue=1, then IDLE next cycle; ap_ready pulses only on DONE entry cycle.
REQ-033 Macro undefined: DONE lasts exactly one cycle then IDLE; ap_continue ignored.

Verification
REQ-034 Mask=4'b1111, size=16384, ch_done on ch0..3 at cycles 5,9,9,20 after ch_start -> ap_done one cycle after ch3 done, busy_cycles=21, ch_xfer_size=16384.
REQ-035 Mask=4'b0101, ch_done on ch1 and ch3 only -> remains RUN, ap_done=0; then ch0, ch2 done -> ap_done asserted.
REQ-036 Mask=4'b0000 with ap_start -> ap_done next cycle, ch_start never asserted, busy_cycles=0.
REQ-037 areset asserted in RUN after 2 of 4 dones -> ap_idle=1, ap_done=0, ch_start=0 next cycle; new start needs all 4 dones.
REQ-038 CHAIN_EN defined, run completes, ap_continue held 0 for 10 cycles -> ap_done=1 for 10 cycles, ap_ready=1 only first cycle; ap_continue=1 -> IDLE next cycle.
REQ-039 ap_start held high across DONE (non-chain) -> second run begins, ch_start one cycle after returning to IDLE, new mask/size latched.
